// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcode constants,
// sequencer state encoding and the source-register usage decode.
package rv_pipe_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int WCNT_W = 8;
  localparam int DCNT_W = 4;

  typedef enum logic [1:0] {
    HS_RUN      = 2'd0,
    HS_MEM_WAIT = 2'd1,
    HS_DRAIN    = 2'd2,
    HS_HALTED   = 2'd3
  } hs_state_t;

  // bit 0 = instruction reads rs1, bit 1 = instruction reads rs2
  function automatic logic [1:0] src_use(input logic [6:0] opc);
    logic [1:0] u;
    u = 2'b00;
    case (opc)
      OPC_R, OPC_I, OPC_LOAD: u = 2'b01;
      OPC_STORE, OPC_BRANCH:  u = 2'b11;
      default:                u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Combinational load-use hazard detection between the load in ID/EX and
// the instruction currently in IF/ID.
module load_use_detect
  import rv_pipe_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);

  logic use1;
  logic use2;
  logic [1:0] uses;

  assign uses = src_use(id_opcode);
  assign use1 = uses[0];
  assign use2 = uses[1];

  // x0 is never a real dependency
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((use1 && (ex_rd == id_rs1)) || (use2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes,
// data-memory waits with watchdog, and debug halt/drain.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// HS_RUN      | normal issue; hazards resolved combinationally this cycle
// HS_MEM_WAIT | data memory busy; pipeline frozen, watchdog counting
// HS_DRAIN    | halt requested; fetch stopped, bubbles flushing pipeline
// HS_HALTED   | pipeline empty and stopped until halt_req drops
module hazard_sequencer
  import rv_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ctrl_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pipe_hold,
  output logic        halted,
  output logic        err_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  hs_state_t          state, state_nxt;
  logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
  logic [DCNT_W-1:0]  dcnt, dcnt_nxt;
  logic               busy_mask, busy_mask_nxt;
  logic               err_nxt;
  logic               load_use;
  logic               br_flush;

  logic               r_pc, r_ifid, r_stall, r_flush, r_hold;
  hs_state_t          r_state;
  logic               use_run;

  load_use_detect u_lud (
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use   (load_use)
  );

  // RUN-state decision, also reused on MEM_WAIT release and HALTED exit.
  // busy_mask hides mem_busy for the single cycle after a watchdog trip.
  always_comb begin
    r_pc    = 1'b1;
    r_ifid  = 1'b1;
    r_stall = 1'b0;
    r_flush = 1'b0;
    r_hold  = 1'b0;
    r_state = HS_RUN;
    if (mem_busy && !busy_mask) begin
      r_pc    = 1'b0;
      r_ifid  = 1'b0;
      r_hold  = 1'b1;
      r_state = HS_MEM_WAIT;
    end else if (branch_taken) begin
      r_flush = 1'b1;
    end else if (load_use) begin
      r_pc    = 1'b0;
      r_ifid  = 1'b0;
      r_stall = 1'b1;
    end else if (halt_req) begin
      r_pc    = 1'b0;
      r_ifid  = 1'b0;
      r_stall = 1'b1;
      r_state = HS_DRAIN;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ctrl_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    pipe_hold     = 1'b0;
    halted        = 1'b0;
    br_flush      = 1'b0;
    use_run       = 1'b0;
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    dcnt_nxt      = dcnt;
    busy_mask_nxt = 1'b0;
    err_nxt       = err_timeout;

    case (state)
      HS_RUN: use_run = 1'b1;

      HS_MEM_WAIT: begin
        if (!mem_busy) begin
          use_run = 1'b1;
        end else begin
          pipe_hold = 1'b1;
          if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
            err_nxt       = 1'b1;
            busy_mask_nxt = 1'b1;
            state_nxt     = HS_RUN;
          end else if (wcnt != {WCNT_W{1'b1}}) begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end

      HS_DRAIN: begin
        ctrl_stall = 1'b1;
        pipe_hold  = mem_busy;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          br_flush    = 1'b1;
        end
        if (!halt_req) begin
          state_nxt = HS_RUN;
        end else if (dcnt == DCNT_W'(PIPE_DEPTH)) begin
          state_nxt = HS_HALTED;
        end else if (!mem_busy) begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end

      HS_HALTED: begin
        if (!halt_req) begin
          use_run = 1'b1;
        end else begin
          halted     = 1'b1;
          ctrl_stall = 1'b1;
        end
      end

      default: state_nxt = HS_RUN;
    endcase

    if (use_run) begin
      pc_write    = r_pc;
      ifid_write  = r_ifid;
      ctrl_stall  = r_stall;
      ifid_flush  = r_flush;
      idex_flush  = r_flush;
      exmem_flush = r_flush;
      pipe_hold   = r_hold;
      br_flush    = r_flush;
      state_nxt   = r_state;
      if (r_state == HS_MEM_WAIT) wcnt_nxt = WCNT_W'(1);
      if (r_state == HS_DRAIN)    dcnt_nxt = DCNT_W'(1);
    end

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_stall  = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pipe_hold   = 1'b0;
      halted      = 1'b0;
      br_flush    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HS_RUN;
      wcnt        <= '0;
      dcnt        <= '0;
      busy_mask   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      dcnt        <= dcnt_nxt;
      busy_mask   <= busy_mask_nxt;
      err_timeout <= err_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (state != HS_HALTED)) stall_cycles <= stall_cycles + 32'd1;
      if (br_flush)                         flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (PIPE_DEPTH=4, MEM_TIMEOUT=16).
module tb_hazard_sequencer;
  import rv_pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, branch_taken, mem_busy, halt_req;
  logic       pc_write, ifid_write, ctrl_stall, ifid_flush, idex_flush, exmem_flush;
  logic       pipe_hold, halted, err_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, ctrl_stall, ifid_flush, idex_flush, exmem_flush, pipe_hold, halted}
  localparam logic [7:0] O_RUN   = 8'b11000000;
  localparam logic [7:0] O_RST   = 8'b00111100;
  localparam logic [7:0] O_STALL = 8'b00100000;
  localparam logic [7:0] O_BR    = 8'b11011100;
  localparam logic [7:0] O_HOLD  = 8'b00000010;
  localparam logic [7:0] O_DRBR  = 8'b00111100;
  localparam logic [7:0] O_DRBSY = 8'b00100010;
  localparam logic [7:0] O_HALT  = 8'b00100001;

  logic [7:0] outs;
  assign outs = {pc_write, ifid_write, ctrl_stall, ifid_flush, idex_flush,
                 exmem_flush, pipe_hold, halted};

  hazard_sequencer #(.PIPE_DEPTH(4), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .halt_req     (halt_req),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ctrl_stall   (ctrl_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_hold    (pipe_hold),
    .halted       (halted),
    .err_timeout  (err_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [7:0] exp);
    chk(tag, 32'(outs), 32'(exp));
  endtask

  // inputs change 1 time unit after the active edge; checks follow 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_memread = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #2;
    chk_o("reset_outputs", O_RST);
    tick(); tick();
    #2;
    chk_o("reset_held", O_RST);
    chk("reset_err", 32'(err_timeout), 32'd0);

    tick(); rst = 1'b0; #2;
    chk_o("run_idle", O_RUN);

    // load-use: ld x5 in EX, add x6,x5,x1 in ID
    tick(); id_opcode = OPC_R; id_rs1 = 5'd5; id_rs2 = 5'd1; ex_rd = 5'd5; ex_memread = 1'b1; #2;
    chk_o("lu_stall", O_STALL);
    tick(); ex_memread = 1'b0; #2;
    chk_o("lu_after_bubble", O_RUN);

    // ex_rd = x0 never stalls
    tick(); id_rs1 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b1; #2;
    chk_o("lu_x0", O_RUN);

    // store reads rs2
    tick(); id_opcode = OPC_STORE; id_rs1 = 5'd3; id_rs2 = 5'd7; ex_rd = 5'd7; #2;
    chk_o("lu_store_rs2", O_STALL);

    // I-type ignores rs2
    tick(); id_opcode = OPC_I; #2;
    chk_o("lu_itype_rs2", O_RUN);

    // branch outranks load-use
    tick(); id_opcode = OPC_R; id_rs1 = 5'd5; ex_rd = 5'd5; branch_taken = 1'b1; #2;
    chk_o("branch_over_lu", O_BR);

    // 3-cycle memory wait, branch suppressed while held
    tick(); clr_in(); mem_busy = 1'b1; #2;
    chk_o("mw_c1", O_HOLD);
    tick(); #2;
    chk_o("mw_c2", O_HOLD);
    tick(); branch_taken = 1'b1; #2;
    chk_o("mw_c3_br_hidden", O_HOLD);
    tick(); mem_busy = 1'b0; #2;
    chk_o("mw_release_br", O_BR);
    chk("mw_err", 32'(err_timeout), 32'd0);
    tick(); branch_taken = 1'b0; #2;
    chk_o("mw_after", O_RUN);

    // watchdog: busy 20 cycles, trips on the 17th busy cycle
    for (int k = 1; k <= 17; k++) begin
      tick(); mem_busy = 1'b1; #2;
      chk_o("wd_hold", O_HOLD);
      chk("wd_err_pre", 32'(err_timeout), 32'd0);
    end
    tick(); #2;
    chk("wd_err_set", 32'(err_timeout), 32'd1);
    chk_o("wd_busy_ignored", O_RUN);
    tick(); #2;
    chk_o("wd_reenter", O_HOLD);
    tick(); #2;
    chk_o("wd_rewait", O_HOLD);
    tick(); mem_busy = 1'b0; #2;
    chk_o("wd_release", O_RUN);
    chk("wd_err_sticky", 32'(err_timeout), 32'd1);

    // halt with full drain, branch flush during drain
    tick(); halt_req = 1'b1; #2;
    chk_o("halt_c0", O_STALL);
    tick(); #2;
    chk_o("halt_c1", O_STALL);
    tick(); branch_taken = 1'b1; #2;
    chk_o("halt_c2_br", O_DRBR);
    tick(); branch_taken = 1'b0; #2;
    chk_o("halt_c3", O_STALL);
    tick(); #2;
    chk_o("halt_c4", O_STALL);
    tick(); #2;
    chk_o("halt_c5_halted", O_HALT);
    tick(); #2;
    chk_o("halt_c6_halted", O_HALT);
    tick(); halt_req = 1'b0; #2;
    chk_o("halt_exit_same_cycle", O_RUN);
    tick(); #2;
    chk_o("halt_exit_next", O_RUN);

    // halt dropped mid-drain; mem_busy during drain
    tick(); halt_req = 1'b1; #2;
    chk_o("abort_c0", O_STALL);
    tick(); mem_busy = 1'b1; #2;
    chk_o("abort_c1_busy", O_DRBSY);
    tick(); mem_busy = 1'b0; halt_req = 1'b0; #2;
    chk_o("abort_c2_drop", O_STALL);
    tick(); #2;
    chk_o("abort_run", O_RUN);
    tick(); #2;
    chk_o("abort_run2", O_RUN);

    // reset in the middle of a memory wait
    tick(); mem_busy = 1'b1; #2;
    chk_o("rmw_c0", O_HOLD);
    tick(); #2;
    chk_o("rmw_c1", O_HOLD);
    tick(); rst = 1'b1; #2;
    chk_o("rmw_forced", O_RST);
    tick(); rst = 1'b0; mem_busy = 1'b0; #2;
    chk_o("rmw_after", O_RUN);
    chk("rmw_err_cleared", 32'(err_timeout), 32'd0);

`ifdef HAZARD_PERF_EN
    tick(); rst = 1'b1; clr_in(); #2;
    tick(); rst = 1'b0; #2;
    chk("perf_reset_stall", stall_cycles, 32'd0);
    chk("perf_reset_flush", flush_count, 32'd0);
    for (int n = 0; n < 5; n++) begin
      tick(); id_opcode = OPC_LOAD; id_rs1 = 5'd9; ex_rd = 5'd9; ex_memread = 1'b1; #2;
      chk_o("perf_lu", O_STALL);
      tick(); ex_memread = 1'b0; #2;
    end
    for (int n = 0; n < 2; n++) begin
      tick(); branch_taken = 1'b1; #2;
      chk_o("perf_br", O_BR);
    end
    tick(); branch_taken = 1'b0; #2;
    chk("perf_stall_cycles", stall_cycles, 32'd5);
    chk("perf_flush_count", flush_count, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
